// File: rtl/requant_round_pipe.sv
// Multi-lane requantiser: arithmetic right shift, selectable rounding, signed saturation.
// Latency 2 cycles, throughput 1 beat/cycle.
// Backpressure: both stages advance only when the output is empty or being taken;
// o_ready mirrors that enable.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid/o_ready       input beat handshake
//   i_dat                 LANES signed IN_W words, lane k at [k*IN_W +: IN_W]
//   i_shift               right-shift amount, clamped to IN_W-1
//   i_round_mode          0 floor, 1 half-up, 2 half-even, 3 half-away-from-zero
//   i_bypass              shift only, output wraps, no rounding or saturation
//   o_valid/i_ready       output beat handshake
//   o_dat                 LANES signed OUT_W words, lane k at [k*OUT_W +: OUT_W]
//   o_sat_max/o_sat_min   per-lane clip indicators for the current output beat
// Optional feature macro REQUANT_SATCNT_EN adds i_sat_cnt_clr and o_sat_cnt, a sticky
// count of transferred output beats that had any lane clipped.
module requant_round_pipe #(
  parameter int LANES = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SH_W  = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES*IN_W-1:0]    i_dat,
  input  logic [SH_W-1:0]          i_shift,
  input  logic [1:0]               i_round_mode,
  input  logic                     i_bypass,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*OUT_W-1:0]   o_dat,
  output logic [LANES-1:0]         o_sat_max,
  output logic [LANES-1:0]         o_sat_min
`ifdef REQUANT_SATCNT_EN
  ,
  input  logic                     i_sat_cnt_clr,
  output logic [31:0]              o_sat_cnt
`endif
);

  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(2**(OUT_W-1)));
  localparam logic [SH_W-1:0]      SH_MAX  = SH_W'(IN_W - 1);

  // Round increment from the bits shifted out: guard g, sticky r, kept lsb l.
  function automatic logic calc_inc(input logic [IN_W-1:0] d,
                                    input logic [SH_W-1:0] s,
                                    input logic [1:0]      mode);
    logic [IN_W-1:0] r_mask;
    logic [IN_W-1:0] d_g;
    logic [IN_W-1:0] d_l;
    logic            g;
    logic            r;
    logic            l;
    logic            inc;
    r_mask = ~({IN_W{1'b1}} << (s - SH_W'(1)));
    d_g    = d >> (s - SH_W'(1));
    d_l    = d >> s;
    g      = d_g[0];
    l      = d_l[0];
    r      = |(d & r_mask);
    case (mode)
      2'd0:    inc = 1'b0;
      2'd1:    inc = g;
      2'd2:    inc = g & (r | l);
      default: inc = g & (r | ~d[IN_W-1]);
    endcase
    // Nothing is shifted out at s=0, so the mask/guard terms are meaningless there.
    if (s == '0) inc = 1'b0;
    return inc;
  endfunction

  logic                               en;
  logic [SH_W-1:0]                    s_clamp;
  logic [LANES-1:0][IN_W-1:0]         in_lane;

  // Stage 1: shifted value plus increment, config travels with the beat.
  logic                               v1_q, v1_d;
  logic                               byp1_q, byp1_d;
  logic [LANES-1:0][IN_W-1:0]         q1_q, q1_d;
  logic [LANES-1:0]                   inc1_q, inc1_d;

  // Stage 2: saturated result and flags, directly driving the outputs.
  logic                               o_valid_q, o_valid_d;
  logic [LANES-1:0][OUT_W-1:0]        o_dat_q, o_dat_d;
  logic [LANES-1:0]                   sat_max_q, sat_max_d;
  logic [LANES-1:0]                   sat_min_q, sat_min_d;
  logic signed [IN_W:0]               sum2 [LANES];

  assign en      = !o_valid_q || i_ready;
  assign o_ready = en;
  assign in_lane = i_dat;
  assign s_clamp = (i_shift > SH_MAX) ? SH_MAX : i_shift;

  always_comb begin
    v1_d   = v1_q;
    byp1_d = byp1_q;
    q1_d   = q1_q;
    inc1_d = inc1_q;
    if (en) begin
      v1_d   = i_valid;
      byp1_d = i_bypass;
      for (int k = 0; k < LANES; k++) begin
        q1_d[k]   = $signed(in_lane[k]) >>> s_clamp;
        inc1_d[k] = i_bypass ? 1'b0 : calc_inc(in_lane[k], s_clamp, i_round_mode);
      end
    end
  end

  // One extra bit of headroom so +max plus an increment cannot wrap before clipping.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sum2[k] = $signed({q1_q[k][IN_W-1], q1_q[k]}) + $signed({{IN_W{1'b0}}, inc1_q[k]});
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_dat_d   = o_dat_q;
    sat_max_d = sat_max_q;
    sat_min_d = sat_min_q;
    if (en) begin
      o_valid_d = v1_q;
      for (int k = 0; k < LANES; k++) begin
        sat_max_d[k] = 1'b0;
        sat_min_d[k] = 1'b0;
        if (byp1_q) begin
          o_dat_d[k] = q1_q[k][OUT_W-1:0];
        end else if (sum2[k] > SAT_MAX) begin
          o_dat_d[k]   = SAT_MAX[OUT_W-1:0];
          sat_max_d[k] = 1'b1;
        end else if (sum2[k] < SAT_MIN) begin
          o_dat_d[k]   = SAT_MIN[OUT_W-1:0];
          sat_min_d[k] = 1'b1;
        end else begin
          o_dat_d[k] = sum2[k][OUT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      byp1_q    <= 1'b0;
      q1_q      <= '0;
      inc1_q    <= '0;
      o_valid_q <= 1'b0;
      o_dat_q   <= '0;
      sat_max_q <= '0;
      sat_min_q <= '0;
    end else begin
      v1_q      <= v1_d;
      byp1_q    <= byp1_d;
      q1_q      <= q1_d;
      inc1_q    <= inc1_d;
      o_valid_q <= o_valid_d;
      o_dat_q   <= o_dat_d;
      sat_max_q <= sat_max_d;
      sat_min_q <= sat_min_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_dat     = o_dat_q;
  assign o_sat_max = sat_max_q;
  assign o_sat_min = sat_min_q;

`ifdef REQUANT_SATCNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;

  // Clear wins over a same-cycle count; the counter sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (o_valid_q && i_ready && (|(sat_max_q | sat_min_q)) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sat_cnt_q <= '0;
    else          sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_requant_round_pipe.sv
// Directed bench for requant_round_pipe (LANES=4, IN_W=16, OUT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge (+1 where noted).
// Expected values are hand-computed per lane.
module tb_requant_round_pipe;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_dat;
  logic [4:0]  i_shift;
  logic [1:0]  i_round_mode;
  logic        i_bypass;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_dat;
  logic [3:0]  o_sat_max;
  logic [3:0]  o_sat_min;
`ifdef REQUANT_SATCNT_EN
  logic        i_sat_cnt_clr;
  logic [31:0] o_sat_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  requant_round_pipe #(.LANES(4), .IN_W(16), .OUT_W(8), .SH_W(5)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_dat        (i_dat),
    .i_shift      (i_shift),
    .i_round_mode (i_round_mode),
    .i_bypass     (i_bypass),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_dat        (o_dat),
    .o_sat_max    (o_sat_max),
    .o_sat_min    (o_sat_min)
`ifdef REQUANT_SATCNT_EN
    ,
    .i_sat_cnt_clr(i_sat_cnt_clr),
    .o_sat_cnt    (o_sat_cnt)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated beat: accepted on the first rising edge, checked two edges later.
  task automatic send_beat(input string tag, input logic [63:0] dat, input logic [4:0] sh,
                           input logic [1:0] mode, input logic byp, input logic [31:0] exp_dat,
                           input logic [3:0] exp_max, input logic [3:0] exp_min);
    @(negedge i_clk);
    i_valid      = 1'b1;
    i_dat        = dat;
    i_shift      = sh;
    i_round_mode = mode;
    i_bypass     = byp;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk($sformatf("%s_lat1", tag), 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk($sformatf("%s_vld", tag), 32'(o_valid), 32'd1);
    chk($sformatf("%s_dat", tag), o_dat, exp_dat);
    chk($sformatf("%s_smax", tag), 32'(o_sat_max), 32'(exp_max));
    chk($sformatf("%s_smin", tag), 32'(o_sat_min), 32'(exp_min));
  endtask

  int          sent;
  int          rcvd;
  logic        prev_stall;
  logic [31:0] prev_dat;
  logic [31:0] exp_s;

  initial begin
    i_rst_n      = 1'b0;
    i_valid      = 1'b0;
    i_ready      = 1'b1;
    i_dat        = '0;
    i_shift      = '0;
    i_round_mode = '0;
    i_bypass     = 1'b0;
`ifdef REQUANT_SATCNT_EN
    i_sat_cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge i_clk);
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_dat", o_dat, 32'd0);
    chk("rst_flags", 32'({o_sat_max, o_sat_min}), 32'd0);
    chk("rst_rdy", 32'(o_ready), 32'd1);
`ifdef REQUANT_SATCNT_EN
    chk("rst_cnt", o_sat_cnt, 32'd0);
`endif
    i_rst_n = 1'b1;

    // Lanes listed lane3..lane0.
    send_beat("half_up", {16'h0000, 16'hFE80, 16'h0080, 16'h0180}, 5'd8, 2'd1, 1'b0,
              32'h00FF0102, 4'h0, 4'h0);
    send_beat("half_even", {16'h0280, 16'h0181, 16'h0180, 16'h0080}, 5'd8, 2'd2, 1'b0,
              32'h02020200, 4'h0, 4'h0);
    send_beat("half_away", {16'h0000, 16'hFF80, 16'h0180, 16'hFE80}, 5'd8, 2'd3, 1'b0,
              32'h00FF02FE, 4'h0, 4'h0);
    send_beat("trunc", {16'h0000, 16'h0000, 16'hFE80, 16'h01FF}, 5'd8, 2'd0, 1'b0,
              32'h0000FE01, 4'h0, 4'h0);
    send_beat("sat", {16'hF7F8, 16'h07F8, 16'h8000, 16'h7FFF}, 5'd4, 2'd1, 1'b0,
              32'h807F807F, 4'b0101, 4'b0010);
    send_beat("bypass", {16'h0000, 16'h1234, 16'h8000, 16'h7FFF}, 5'd4, 2'd1, 1'b1,
              32'h002300FF, 4'h0, 4'h0);
    send_beat("sh_clamp", {16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000}, 5'd31, 2'd1, 1'b0,
              32'h000001FF, 4'h0, 4'h0);
    send_beat("sh_zero", {16'h0080, 16'h007F, 16'hFFFF, 16'h0005}, 5'd0, 2'd1, 1'b0,
              32'h7F7FFF05, 4'b1000, 4'h0);

    // Streaming with a downstream stall on cycles 3-5.
    sent       = 0;
    rcvd       = 0;
    prev_stall = 1'b0;
    prev_dat   = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge i_clk);
      i_ready      = !(c >= 3 && c <= 5);
      i_valid      = (sent < 8);
      i_dat        = {16'(sent*4+3), 16'(sent*4+2), 16'(sent*4+1), 16'(sent*4)};
      i_shift      = '0;
      i_round_mode = 2'd0;
      i_bypass     = 1'b0;
      #1;
      if (!i_ready) begin
        chk("stall_rdy", 32'(o_ready), 32'd0);
        if (prev_stall && o_valid) chk("stall_hold", o_dat, prev_dat);
      end
      if (o_valid && i_ready) begin
        exp_s = {8'(rcvd*4+3), 8'(rcvd*4+2), 8'(rcvd*4+1), 8'(rcvd*4)};
        chk($sformatf("stream_%0d", rcvd), o_dat, exp_s);
        rcvd++;
      end
      if (i_valid && o_ready) sent++;
      prev_stall = !i_ready;
      prev_dat   = o_dat;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("stream_cnt", 32'(rcvd), 32'd8);

    // Reset with two beats in flight drops both.
    @(negedge i_clk);
    i_valid      = 1'b1;
    i_dat        = {16'h0000, 16'h0000, 16'h0000, 16'h0180};
    i_shift      = 5'd8;
    i_round_mode = 2'd1;
    @(negedge i_clk);
    i_dat = {16'h0000, 16'h0000, 16'h0000, 16'h0280};
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("inflight_vld", 32'(o_valid), 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_vld", 32'(o_valid), 32'd0);
    chk("mid_rst_dat", o_dat, 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk($sformatf("dropped_%0d", i), 32'(o_valid), 32'd0);
    end

`ifdef REQUANT_SATCNT_EN
    chk("cnt_after_rst", o_sat_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_beat($sformatf("cnt_sat%0d", i), {16'hF7F8, 16'h07F8, 16'h8000, 16'h7FFF}, 5'd4,
                2'd1, 1'b0, 32'h807F807F, 4'b0101, 4'b0010);
    end
    send_beat("cnt_clean", {16'h0000, 16'hFE80, 16'h0080, 16'h0180}, 5'd8, 2'd1, 1'b0,
              32'h00FF0102, 4'h0, 4'h0);
    @(negedge i_clk);
    chk("cnt_three", o_sat_cnt, 32'd3);
    send_beat("cnt_clrbeat", {16'hF7F8, 16'h07F8, 16'h8000, 16'h7FFF}, 5'd4, 2'd1, 1'b0,
              32'h807F807F, 4'b0101, 4'b0010);
    i_sat_cnt_clr = 1'b1;
    @(negedge i_clk);
    i_sat_cnt_clr = 1'b0;
    chk("cnt_clr_prio", o_sat_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
